// File: rtl/tone_gen_pkg.sv
// Shared widths, address map and write-front-end FSM encoding for the tone generator.
// The StEnd state exists only when SPI_FRAME_CHECK_EN is defined.
package tone_gen_pkg;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int FRAME_BITS = ADDR_W + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [ADDR_W-1:0] REG_INCR_BASE = 4'h0;
    localparam logic [ADDR_W-1:0] REG_VOL_BASE  = 4'h4;
    localparam logic [ADDR_W-1:0] REG_WAVE      = 4'h8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StShift  = 3'd1,
        StCommit = 3'd2,
        StDrain  = 3'd3
`ifdef SPI_FRAME_CHECK_EN
        , StEnd  = 3'd4
`endif
    } wr_state_e;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit, with a selectable reset value.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 write-frame receiver issuing single-cycle register writes to the tone core.
// Define SPI_FRAME_CHECK_EN to defer commit to CS release and flag malformed frames.
module spi_reg_writer
    import tone_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              spi_sck_in,
    input  logic              spi_cs_n_in,
    input  logic              spi_mosi_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic              frame_err_out
);

    logic sck_s, cs_s, mosi_s;
    logic sck_prev_q, cs_prev_q;
    logic sck_rise, cs_rise, cs_fall;

    // CS resets to asserted so a frame already running at reset release is never started.
    bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk_in), .rst_n(reset_n_in), .d(spi_sck_in), .q(sck_s)
    );
    bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk_in), .rst_n(reset_n_in), .d(spi_cs_n_in), .q(cs_s)
    );
    bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk_in), .rst_n(reset_n_in), .d(spi_mosi_in), .q(mosi_s)
    );

    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    wr_state_e              state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
`ifdef SPI_FRAME_CHECK_EN
    logic                   overrun_q, overrun_d;
    logic                   err_q, err_d;
`endif

    assign cnt_inc = bit_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
`ifdef SPI_FRAME_CHECK_EN
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
`ifdef SPI_FRAME_CHECK_EN
            overrun_q  <= overrun_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
`ifdef SPI_FRAME_CHECK_EN
        overrun_d = overrun_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (sck_rise) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
                    bit_cnt_d = cnt_inc;
                end
                // SCK is handled before CS, so a final bit coinciding with CS release counts.
                if (sck_rise && (cnt_inc == CNT_W'(FRAME_BITS))) begin
`ifdef SPI_FRAME_CHECK_EN
                    overrun_d = 1'b0;
                    state_d   = cs_rise ? StCommit : StEnd;
`else
                    state_d   = StCommit;
`endif
                end else if (cs_rise) begin
                    state_d = StIdle;
`ifdef SPI_FRAME_CHECK_EN
                    err_d   = (bit_cnt_d != '0);
`endif
                end
            end
            StCommit: begin
                addr_d  = shift_q[FRAME_BITS-1 -: ADDR_W];
                data_d  = shift_q[DATA_W-1:0];
                valid_d = 1'b1;
`ifdef SPI_FRAME_CHECK_EN
                state_d = StIdle;
`else
                state_d = StDrain;
`endif
            end
            StDrain: begin
                // Level test also covers a CS release that coincided with the final bit.
                if (cs_s) begin
                    state_d = StIdle;
                end
            end
`ifdef SPI_FRAME_CHECK_EN
            StEnd: begin
                if (sck_rise) begin
                    overrun_d = 1'b1;
                end
                if (cs_rise) begin
                    if (overrun_q || sck_rise) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign addr_out       = addr_q;
    assign data_out       = data_q;
    assign data_valid_out = valid_q;
`ifdef SPI_FRAME_CHECK_EN
    assign frame_err_out  = err_q;
`else
    assign frame_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer; adapts expectations when SPI_FRAME_CHECK_EN is defined.
module tb_spi_reg_writer;

    localparam int S = 2;
    localparam int H = S + 2;
`ifdef SPI_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_sck, spi_cs_n, spi_mosi;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        data_valid, frame_err;

    spi_reg_writer #(.SYNC_STAGES(S)) dut (
        .clk_in(clk), .reset_n_in(reset_n), .spi_sck_in(spi_sck), .spi_cs_n_in(spi_cs_n),
        .spi_mosi_in(spi_mosi), .addr_out(addr), .data_out(data),
        .data_valid_out(data_valid), .frame_err_out(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          nbits;
        logic [3:0]  extra;
        bit          exp_write;
        bit          exp_err;
        bit          settle;
    } vec_t;

    int          tests = 0, fails = 0;
    int          cyc = 0, trig_cyc = 0, last_valid_cyc = 0;
    int          writes_seen = 0, errs_seen = 0, exp_writes = 0, exp_errs = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_w;
    logic [3:0]  last_addr = '0;
    logic [15:0] last_data = '0;
    vec_t        vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write strobe pops one expected (addr, data) record.
    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            tests++;
            writes_seen++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr=0x%0h data=0x%0h, required no write",
                         addr, data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({addr, data} !== exp_w) begin
                    fails++;
                    $display("FAIL write_value: got 0x%05h required 0x%05h", {addr, data}, exp_w);
                end
            end
        end
        if (reset_n && frame_err) errs_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit is_trig);
        spi_mosi = b;
        wait_cyc(H);
        spi_sck = 1'b1;
        if (is_trig) trig_cyc = cyc;
        wait_cyc(H);
        spi_sck = 1'b0;
    endtask

    task automatic expect_frame(input logic [3:0] a, input logic [15:0] d, input bit w,
                                input bit e);
        if (w) begin
            exp_q.push_back({a, d});
            exp_writes++;
            last_addr = a;
            last_data = d;
        end
        if (e) exp_errs++;
    endtask

    // Sends the top nbits of {a, d, x} MSB first; sim_end releases CS with the final SCK rise.
    task automatic send_frame(input logic [3:0] a, input logic [15:0] d, input logic [3:0] x,
                              input int nbits, input bit sim_end);
        logic [23:0] f;
        f = {a, d, x};
        spi_cs_n = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < nbits; i++) begin
            if (sim_end && i == nbits - 1) begin
                spi_mosi = f[23-i];
                wait_cyc(H);
                spi_sck  = 1'b1;
                spi_cs_n = 1'b1;
                trig_cyc = cyc;
                wait_cyc(H);
                spi_sck  = 1'b0;
            end else begin
                send_bit(f[23-i], !CHK && i == 19);
            end
        end
        if (!sim_end) begin
            wait_cyc(H);
            spi_cs_n = 1'b1;
            if (CHK) trig_cyc = cyc;
        end
        wait_cyc(H);
    endtask

    task automatic settle_and_check(input string tag);
        wait_cyc(H + 2);
        check({tag, "_writes"}, writes_seen, exp_writes);
        check({tag, "_errs"}, errs_seen, exp_errs);
        check({tag, "_addr_hold"}, {28'd0, addr}, {28'd0, last_addr});
        check({tag, "_data_hold"}, {16'd0, data}, {16'd0, last_data});
    endtask

    initial begin
        vecs[0] = '{4'h1, 16'h1234, 20, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{4'h4, 16'h00FF, 20, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'h8, 16'h0003, 20, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{4'h6, 16'h9C00, 12, 4'h0, 1'b0, CHK,  1'b1};
        vecs[4] = '{4'h2, 16'hABCD, 24, 4'h5, !CHK, CHK,  1'b1};
        vecs[5] = '{4'hE, 16'hFFFF, 20, 4'h0, 1'b1, 1'b0, 1'b1};

        reset_n  = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_cyc(3);
        check("reset_addr", {28'd0, addr}, 32'd0);
        check("reset_data", {16'd0, data}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(S + 4);

        for (int i = 0; i < 6; i++) begin
            expect_frame(vecs[i].addr, vecs[i].data, vecs[i].exp_write, vecs[i].exp_err);
            send_frame(vecs[i].addr, vecs[i].data, vecs[i].extra, vecs[i].nbits, 1'b0);
            if (vecs[i].settle) begin
                settle_and_check($sformatf("vec%0d", i));
                if (i == 0) check("vec0_latency", last_valid_cyc - trig_cyc, S + 2);
            end
        end

        // Reset lands after bit 7 while CS stays low; the rest of that frame must be ignored.
        spi_cs_n = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < 7; i++) send_bit(i[0], 1'b0);
        reset_n = 1'b0;
        last_addr = '0;
        last_data = '0;
        wait_cyc(2);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 13; i++) send_bit(~i[0], 1'b0);
        wait_cyc(H);
        spi_cs_n = 1'b1;
        wait_cyc(H);
        settle_and_check("midrst");
        check("midrst_err_pin", {31'd0, frame_err}, 32'd0);

        expect_frame(4'hF, 16'h8001, 1'b1, 1'b0);
        send_frame(4'hF, 16'h8001, 4'h0, 20, 1'b0);
        settle_and_check("after_rst");

        // Bit 20 and CS release reach the edge detectors in the same cycle.
        expect_frame(4'h3, 16'h5A5A, 1'b1, 1'b0);
        send_frame(4'h3, 16'h5A5A, 4'h0, 20, 1'b1);
        settle_and_check("simul");
        check("simul_latency", last_valid_cyc - trig_cyc, S + 2);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
